// File: rtl/forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
//
// Purpose:
//   EX-stage operand forwarding selector for the 5-stage RV32 pipeline. The
//   ID/EX source registers are compared against the EX/MEM and MEM/WB
//   destinations. The result drives the ALU operand mux selects. Clocked,
//   saturating event counters count forwarding activity; they never influence
//   the selects.
//
// Select encoding (forward_a / forward_b):
//   2'b00 register-file value, 2'b10 EX/MEM ALU result,
//   2'b01 MEM/WB write-back value; 2'b11 is never driven.
//
// Ports:
//   clk, rst_n          clock (counters only), async active-low reset
//   id_ex_rs1/rs2       source register indices of the instruction in EX
//   ex_mem_rd           EX/MEM destination index
//   mem_wb_rd           MEM/WB destination index
//   ex_mem_reg_write    EX/MEM instruction writes the register file
//   mem_wb_reg_write    MEM/WB instruction writes the register file
//   stat_clr            synchronous clear of both counters (beats increments)
//   forward_a/b         ALU operand A/B selects (combinational)
//   cnt_ex_fwd          operands forwarded from EX/MEM (saturating)
//   cnt_wb_fwd          operands forwarded from MEM/WB (saturating)
//
// Optional build macro FWD_STORE_DATA_EN:
//   Adds MEM-stage store-data forwarding for a load followed by a store.
//   Extra inputs ex_mem_rs2, ex_mem_mem_write and mem_wb_mem_to_reg.
//   Extra output forward_mem. Each edge with forward_mem=1 also counts into
//   cnt_wb_fwd.
// -----------------------------------------------------------------------------
module forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  ex_mem_reg_write,
  input  logic                  mem_wb_reg_write,
  input  logic                  stat_clr,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic [CNT_W-1:0]      cnt_ex_fwd,
  output logic [CNT_W-1:0]      cnt_wb_fwd
`ifdef FWD_STORE_DATA_EN
  ,
  input  logic [REG_ADDR_W-1:0] ex_mem_rs2,
  input  logic                  ex_mem_mem_write,
  input  logic                  mem_wb_mem_to_reg,
  output logic                  forward_mem
`endif
);

  // A stage may forward only if it writes a real register; x0 is hard-wired
  // to zero and must never be forwarded.
  logic ex_live, wb_live;
  logic a_from_ex, a_from_wb, b_from_ex, b_from_wb;

  assign ex_live = ex_mem_reg_write && (ex_mem_rd != '0);
  assign wb_live = mem_wb_reg_write && (mem_wb_rd != '0);

  // EX/MEM wins over MEM/WB because it holds the more recent result.
  assign a_from_ex = ex_live && (ex_mem_rd == id_ex_rs1);
  assign b_from_ex = ex_live && (ex_mem_rd == id_ex_rs2);
  assign a_from_wb = !a_from_ex && wb_live && (mem_wb_rd == id_ex_rs1);
  assign b_from_wb = !b_from_ex && wb_live && (mem_wb_rd == id_ex_rs2);

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (a_from_ex)      forward_a = 2'b10;
    else if (a_from_wb) forward_a = 2'b01;
    if (b_from_ex)      forward_b = 2'b10;
    else if (b_from_wb) forward_b = 2'b01;
  end

`ifdef FWD_STORE_DATA_EN
  // A load in MEM/WB feeding the store data of the store now in EX/MEM.
  assign forward_mem = ex_mem_mem_write && mem_wb_reg_write && mem_wb_mem_to_reg &&
                       (mem_wb_rd != '0) && (mem_wb_rd == ex_mem_rs2);
`endif

  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
  logic [1:0]       ex_inc, wb_inc;
  logic [CNT_W-1:0] cnt_ex_q, cnt_ex_d;
  logic [CNT_W-1:0] cnt_wb_q, cnt_wb_d;

  // The increment is at most 3 (two selects plus store data), so a 2-bit
  // headroom on the sum is enough to detect overflow and clamp to all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
    if (sum > {2'b00, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    else                               return sum[CNT_W-1:0];
  endfunction

  always_comb begin
    ex_inc = {1'b0, a_from_ex} + {1'b0, b_from_ex};
    wb_inc = {1'b0, a_from_wb} + {1'b0, b_from_wb}
`ifdef FWD_STORE_DATA_EN
             + {1'b0, forward_mem}
`endif
             ;
    if (stat_clr) begin
      cnt_ex_d = '0;
      cnt_wb_d = '0;
    end else begin
      cnt_ex_d = sat_add(cnt_ex_q, ex_inc);
      cnt_wb_d = sat_add(cnt_wb_q, wb_inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ex_q <= '0;
      cnt_wb_q <= '0;
    end else begin
      cnt_ex_q <= cnt_ex_d;
      cnt_wb_q <= cnt_wb_d;
    end
  end

  assign cnt_ex_fwd = cnt_ex_q;
  assign cnt_wb_fwd = cnt_wb_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// -----------------------------------------------------------------------------
// tb_forwarding_unit
//   Directed, table-driven bench for forwarding_unit. A 16-bit-counter
//   instance and a 2-bit-counter instance share the same stimulus, so
//   saturation can be observed within a few edges.
// -----------------------------------------------------------------------------
module tb_forwarding_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic [4:0]  id_ex_rs1, id_ex_rs2, ex_mem_rd, mem_wb_rd;
  logic        ex_mem_reg_write, mem_wb_reg_write, stat_clr;
  logic [1:0]  forward_a, forward_b, forward_a_s, forward_b_s;
  logic [15:0] cnt_ex_fwd, cnt_wb_fwd;
  logic [1:0]  cnt_ex_s, cnt_wb_s;
`ifdef FWD_STORE_DATA_EN
  logic [4:0]  ex_mem_rs2;
  logic        ex_mem_mem_write, mem_wb_mem_to_reg;
  logic        forward_mem, forward_mem_s;
  assign ex_mem_rs2        = 5'd0;
  assign ex_mem_mem_write  = 1'b0;
  assign mem_wb_mem_to_reg = 1'b0;
`endif

  forwarding_unit #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_ex_rs1        (id_ex_rs1),
    .id_ex_rs2        (id_ex_rs2),
    .ex_mem_rd        (ex_mem_rd),
    .mem_wb_rd        (mem_wb_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_reg_write (mem_wb_reg_write),
    .stat_clr         (stat_clr),
    .forward_a        (forward_a),
    .forward_b        (forward_b),
    .cnt_ex_fwd       (cnt_ex_fwd),
    .cnt_wb_fwd       (cnt_wb_fwd)
`ifdef FWD_STORE_DATA_EN
    ,
    .ex_mem_rs2       (ex_mem_rs2),
    .ex_mem_mem_write (ex_mem_mem_write),
    .mem_wb_mem_to_reg(mem_wb_mem_to_reg),
    .forward_mem      (forward_mem)
`endif
  );

  forwarding_unit #(.REG_ADDR_W(5), .CNT_W(2)) u_dut_small (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_ex_rs1        (id_ex_rs1),
    .id_ex_rs2        (id_ex_rs2),
    .ex_mem_rd        (ex_mem_rd),
    .mem_wb_rd        (mem_wb_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_reg_write (mem_wb_reg_write),
    .stat_clr         (stat_clr),
    .forward_a        (forward_a_s),
    .forward_b        (forward_b_s),
    .cnt_ex_fwd       (cnt_ex_s),
    .cnt_wb_fwd       (cnt_wb_s)
`ifdef FWD_STORE_DATA_EN
    ,
    .ex_mem_rs2       (ex_mem_rs2),
    .ex_mem_mem_write (ex_mem_mem_write),
    .mem_wb_mem_to_reg(mem_wb_mem_to_reg),
    .forward_mem      (forward_mem_s)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int tests_run = 0;
  int tests_failed = 0;
  int exp_ex = 0, exp_wb = 0;      // model of the 16-bit counters
  int exp_ex_s = 0, exp_wb_s = 0;  // model of the 2-bit counters

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, " cnt_ex_fwd"},   cnt_ex_fwd,        16'(exp_ex));
    check({tag, " cnt_wb_fwd"},   cnt_wb_fwd,        16'(exp_wb));
    check({tag, " cnt_ex_fwd/2"}, {14'd0, cnt_ex_s}, 16'(exp_ex_s));
    check({tag, " cnt_wb_fwd/2"}, {14'd0, cnt_wb_s}, 16'(exp_wb_s));
  endtask

  // Advance the counter model by one edge, from the bench's own expected selects.
  task automatic model_edge(input logic [1:0] ea, input logic [1:0] eb);
    int ex_inc, wb_inc;
    ex_inc = ((ea == 2'b10) ? 1 : 0) + ((eb == 2'b10) ? 1 : 0);
    wb_inc = ((ea == 2'b01) ? 1 : 0) + ((eb == 2'b01) ? 1 : 0);
    exp_ex   = (exp_ex + ex_inc > 65535) ? 65535 : exp_ex + ex_inc;
    exp_wb   = (exp_wb + wb_inc > 65535) ? 65535 : exp_wb + wb_inc;
    exp_ex_s = (exp_ex_s + ex_inc > 3) ? 3 : exp_ex_s + ex_inc;
    exp_wb_s = (exp_wb_s + wb_inc > 3) ? 3 : exp_wb_s + wb_inc;
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] rs1, rs2, exrd, wbrd;
    logic       exwr, wbwr;
    logic [1:0] ea, eb;
  } vec_t;

  task automatic drive(input vec_t v);
    id_ex_rs1        = v.rs1;
    id_ex_rs2        = v.rs2;
    ex_mem_rd        = v.exrd;
    mem_wb_rd        = v.wbrd;
    ex_mem_reg_write = v.exwr;
    mem_wb_reg_write = v.wbwr;
  endtask

  vec_t vecs[12];
  vec_t both_ex;
  vec_t idle;

  initial begin
    //            rs1    rs2    exrd   wbrd   exwr  wbwr  ea     eb
    vecs[0]  = '{5'd21, 5'd0,  5'd21, 5'd0,  1'b1, 1'b0, 2'b10, 2'b00}; // EX hazard on A
    vecs[1]  = '{5'd21, 5'd0,  5'd10, 5'd21, 1'b0, 1'b1, 2'b01, 2'b00}; // WB hazard on A
    vecs[2]  = '{5'd3,  5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 2'b00, 2'b10}; // double on B
    vecs[3]  = '{5'd31, 5'd31, 5'd10, 5'd0,  1'b1, 1'b0, 2'b00, 2'b00}; // no hazard
    vecs[4]  = '{5'd0,  5'd4,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00}; // x0 guard
    vecs[5]  = '{5'd9,  5'd9,  5'd9,  5'd9,  1'b0, 1'b0, 2'b00, 2'b00}; // match, no write
    vecs[6]  = '{5'd7,  5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 2'b10, 2'b10}; // both from EX
    vecs[7]  = '{5'd7,  5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 2'b10, 2'b10}; // both from EX again
    vecs[8]  = '{5'd12, 5'd12, 5'd5,  5'd12, 1'b1, 1'b1, 2'b01, 2'b01}; // both from WB
    vecs[9]  = '{5'd5,  5'd12, 5'd5,  5'd12, 1'b1, 1'b1, 2'b10, 2'b01}; // mixed stages
    vecs[10] = '{5'd6,  5'd0,  5'd6,  5'd6,  1'b0, 1'b1, 2'b01, 2'b00}; // EX disabled -> WB
    vecs[11] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 2'b00, 2'b00}; // idle
    both_ex  = vecs[6];
    idle     = vecs[11];

    // Reset phase: counters held at 0, selects still live through reset.
    rst_n    = 1'b0;
    stat_clr = 1'b0;
    drive(vecs[0]);
    #2;
    check("reset forward_a", {14'd0, forward_a}, 16'd2);
    check("reset forward_b", {14'd0, forward_b}, 16'd0);
    check_counters("reset");
    #10; // past the edge at t=5 with a hazard present
    check_counters("reset after edge");
    drive(idle);
    rst_n = 1'b1;

    // Table-driven vectors: selects checked combinationally, counters after the edge.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d forward_a", i), {14'd0, forward_a}, {14'd0, vecs[i].ea});
      check($sformatf("vec%0d forward_b", i), {14'd0, forward_b}, {14'd0, vecs[i].eb});
      check($sformatf("vec%0d forward_a/2", i), {14'd0, forward_a_s}, {14'd0, vecs[i].ea});
      @(posedge clk);
      #1;
      model_edge(vecs[i].ea, vecs[i].eb);
      check_counters($sformatf("vec%0d", i));
    end

    // Mid-cycle reset: counters clear immediately, counting resumes after release.
    drive(both_ex);
    #3;
    rst_n = 1'b0;
    #1;
    exp_ex = 0; exp_wb = 0; exp_ex_s = 0; exp_wb_s = 0;
    check_counters("mid reset");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_edge(2'b10, 2'b10);
    check_counters("after reset edge1"); // 2 / 2
    @(posedge clk);
    #1;
    model_edge(2'b10, 2'b10);
    check_counters("after reset edge2"); // 4 / saturated 3
    @(posedge clk);
    #1;
    model_edge(2'b10, 2'b10);
    check_counters("after reset edge3"); // 6 / still 3

    // stat_clr beats the concurrent hazard increment.
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    exp_ex = 0; exp_wb = 0; exp_ex_s = 0; exp_wb_s = 0;
    check_counters("stat_clr");
    stat_clr = 1'b0;
    @(posedge clk);
    #1;
    model_edge(2'b10, 2'b10);
    check_counters("after clr");

    drive(idle);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Combinational EX-stage operand forwarding selector for the 5-stage pipelined RV32 core.
- Compares ID/EX source registers against the destination registers in EX/MEM and MEM/WB. Drives the ALU operand mux selects forward_a and forward_b.
- Also holds clocked, saturating forwarding-event counters for performance visibility. Counters do not affect the selects.

Parameters:
- REG_ADDR_W, 5, register index width (RV32 x0..x31).
- CNT_W, 16, width of each event counter.

Ports:
- Single clock domain. Reset is asynchronous, active-low.
- clk  in  1  rising-edge clock; used by the counters only.
- rst_n  in  1  asynchronous active-low reset.
- id_ex_rs1  in  REG_ADDR_W  rs1 index of the instruction in EX.
- id_ex_rs2  in  REG_ADDR_W  rs2 index of the instruction in EX.
- ex_mem_rd  in  REG_ADDR_W  destination index in EX/MEM.
- mem_wb_rd  in  REG_ADDR_W  destination index in MEM/WB.
- ex_mem_reg_write  in  1  EX/MEM instruction writes the register file.
- mem_wb_reg_write  in  1  MEM/WB instruction writes the register file.
- stat_clr  in  1  synchronous clear of all counters.
- forward_a  out  2  ALU operand A select.
- forward_b  out  2  ALU operand B select.
- cnt_ex_fwd  out  CNT_W  count of operands forwarded from EX/MEM.
- cnt_wb_fwd  out  CNT_W  count of operands forwarded from MEM/WB.

Behaviour:
- Select encoding:
  - 2'b00: register-file value from ID/EX.
  - 2'b10: EX/MEM ALU result.
  - 2'b01: MEM/WB write-back value.
  - 2'b11 is never driven.
- forward_a is purely combinational, zero latency, and does not depend on clk or rst_n:
  - 10 if ex_mem_reg_write=1, ex_mem_rd!=0 and ex_mem_rd==id_ex_rs1;
  - else 01 if mem_wb_reg_write=1, mem_wb_rd!=0 and mem_wb_rd==id_ex_rs1;
  - else 00.
- forward_b: same rule applied to id_ex_rs2, evaluated independently of forward_a.
- EX/MEM has priority over MEM/WB when both match, because it holds the more recent result.
- x0 is never forwarded. Any rd==0 match yields 00.
- A matching rd with its reg_write=0 does not forward.
- Both selects may be non-zero in the same cycle, including both from the same stage.
- Counters:
  - Each rising clk edge, cnt_ex_fwd adds the number of selects (0, 1 or 2) equal to 10.
  - In the same edge, cnt_wb_fwd adds the number of selects equal to 01.
  - Counters saturate at all-ones; they never wrap.
- stat_clr=1 zeroes both counters on the next edge. It takes priority over increments in that cycle.
- Reset: rst_n=0 asynchronously clears both counters to 0. forward_a and forward_b stay combinational through reset.
- Reset asserted mid-operation clears the counters immediately. Counting resumes on the first edge after deassertion.

Optional Feature:
- Macro FWD_STORE_DATA_EN adds MEM-stage store-data forwarding (load followed by store).
- Extra inputs:
  - ex_mem_rs2 (REG_ADDR_W);
  - ex_mem_mem_write (1);
  - mem_wb_mem_to_reg (1).
- Extra output forward_mem (1):
  - 1 when ex_mem_mem_write=1, mem_wb_reg_write=1, mem_wb_mem_to_reg=1, mem_wb_rd!=0 and mem_wb_rd==ex_mem_rs2;
  - else 0.
  - Combinational.
- Each edge with forward_mem=1 also increments cnt_wb_fwd, with the same saturation rule.
- Without the macro: none of these ports exist, and the counters behave as described in Behaviour.

Test Plan:
- EX hazard on A: ex_mem_rd=5'b10101, ex_mem_reg_write=1, id_ex_rs1=5'b10101 -> forward_a=10, forward_b=00. After 1 edge, cnt_ex_fwd=1.
- WB hazard on A: mem_wb_rd=5'b10101, mem_wb_reg_write=1, ex_mem_rd=5'b01010, ex_mem_reg_write=0, id_ex_rs1=5'b10101 -> forward_a=01. After 1 edge, cnt_wb_fwd increments by 1.
- Double hazard on B: ex_mem_rd=mem_wb_rd=id_ex_rs2=5'b11111, both reg_write=1 -> forward_b=10 (EX/MEM priority).
- No hazard and x0 guard:
  - mem_wb_reg_write=0, ex_mem_rd=5'b01010, id_ex_rs1=id_ex_rs2=5'b11111 -> both selects 00.
  - ex_mem_rd=0, ex_mem_reg_write=1, id_ex_rs1=0 -> forward_a=00.
- Both operands from EX: id_ex_rs1=id_ex_rs2=ex_mem_rd=5'd7, ex_mem_reg_write=1 -> forward_a=10, forward_b=10. cnt_ex_fwd increases by 2 per edge. With CNT_W=2 it saturates at 3.
- Reset and clear:
  - Assert rst_n=0 between edges -> counters read 0 immediately.
  - With counters non-zero, drive stat_clr=1 alongside an active hazard -> counters are 0 after that edge.
